// File: rtl/sdram_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sdram_port_arbiter_pkg
//   Shared widths and the FSM state type for the SDRAM port arbiter.
//   ADDR_W            : SDRAM start-address width
//   LEN_W             : burst-length width (also the beat counter width)
//   SDRAM_DATA_WIDTH  : controller data-bus width
//   arb_state_t       : IDLE / REQ / BURST / DONE
// ---------------------------------------------------------------------------
package sdram_port_arbiter_pkg;

    localparam int ADDR_W           = 24;
    localparam int LEN_W            = 10;
    localparam int SDRAM_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_BURST = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/sdram_rr_picker.sv
// ---------------------------------------------------------------------------
// sdram_rr_picker
//   Combinational round-robin selector: the first eligible port at or after
//   rr_ptr, searching cyclically.
//   eligible : per-port "may be granted" vector
//   rr_ptr   : index the search starts from
//   pick     : one-hot winner (0 when nothing is eligible)
//   pick_idx : binary index of the winner (0 when nothing is eligible)
// ---------------------------------------------------------------------------
module sdram_rr_picker #(
    parameter int NPORT = 4,
    parameter int IDX_W = 2
) (
    input  logic [NPORT-1:0] eligible,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [NPORT-1:0] pick,
    output logic [IDX_W-1:0] pick_idx
);

    always_comb begin
        logic [IDX_W:0] sum;
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        pick     = '0;
        pick_idx = '0;
        sum      = '0;
        // Walk offsets from the farthest to the nearest; the nearest eligible
        // port is assigned last and therefore wins.
        for (int k = NPORT - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
            if (sum >= (IDX_W + 1)'(NPORT)) sum = sum - (IDX_W + 1)'(NPORT);
            if (eligible[sum[IDX_W-1:0]]) begin
                pick                    = '0;
                pick[sum[IDX_W-1:0]]    = 1'b1;
                pick_idx                = sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_port_arbiter
//   Shares one SDRAM controller burst port among NPORT requesters with
//   round-robin grants. The winner's address, length and direction are
//   latched; ack, write data and done/error status are routed to the winner.
//   clk_ref, rst_n                  : clock, async active-low reset
//   sdram_init_done                 : no new grant while low
//   port_req/we/addr/len/din        : per-port request side (packed vectors)
//   port_ack, port_dout             : per-port data strobe, broadcast read data
//   port_grant, port_done, port_err : one-hot owner, end-of-burst pulses
//   sdram_{wr,rd}_{req,ack,addr,burst}, sdram_din, sdram_dout : controller side
// ---------------------------------------------------------------------------
module sdram_port_arbiter
    import sdram_port_arbiter_pkg::*;
#(
    parameter int NPORT   = 4,
    parameter int TIMEOUT = 1023,
    parameter int HOLDOFF = 2,
    parameter int DW      = SDRAM_DATA_WIDTH
) (
    input  logic                    clk_ref,
    input  logic                    rst_n,
    input  logic                    sdram_init_done,
    input  logic [NPORT-1:0]        port_req,
    input  logic [NPORT-1:0]        port_we,
    input  logic [NPORT*ADDR_W-1:0] port_addr,
    input  logic [NPORT*LEN_W-1:0]  port_len,
    input  logic [NPORT*DW-1:0]     port_din,
    output logic [NPORT-1:0]        port_ack,
    output logic [DW-1:0]           port_dout,
    output logic [NPORT-1:0]        port_grant,
    output logic [NPORT-1:0]        port_done,
    output logic [NPORT-1:0]        port_err,
    output logic                    sdram_wr_req,
    output logic                    sdram_rd_req,
    input  logic                    sdram_wr_ack,
    input  logic                    sdram_rd_ack,
    output logic [ADDR_W-1:0]       sdram_wr_addr,
    output logic [ADDR_W-1:0]       sdram_rd_addr,
    output logic [LEN_W-1:0]        sdram_wr_burst,
    output logic [LEN_W-1:0]        sdram_rd_burst,
    output logic [DW-1:0]           sdram_din,
    input  logic [DW-1:0]           sdram_dout
);

    localparam int IDX_W  = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    arb_state_t        state;
    logic [IDX_W-1:0]  g, rr_ptr, pick_idx;
    logic [NPORT-1:0]  eligible, pick;
    logic              we_q, ack_sel, ack_r, err_q, active;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q, beats, beats_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [HOLD_W-1:0] holdoff [NPORT];

    logic [ADDR_W-1:0] addr_arr [NPORT];
    logic [LEN_W-1:0]  len_arr  [NPORT];
    logic [DW-1:0]     din_arr  [NPORT];

    for (genvar i = 0; i < NPORT; i++) begin : g_unpack
        assign addr_arr[i] = port_addr[i*ADDR_W +: ADDR_W];
        assign len_arr[i]  = port_len[i*LEN_W +: LEN_W];
        assign din_arr[i]  = port_din[i*DW +: DW];
    end

    // A just-served port sits out HOLDOFF cycles so its registered FIFO-level
    // request has time to fall before it can win again.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NPORT; i++) eligible[i] = port_req[i] && (holdoff[i] == '0);
    end

    sdram_rr_picker #(.NPORT(NPORT), .IDX_W(IDX_W)) u_picker (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    // Only the latched direction's ack is observed; the other one is ignored.
    assign ack_sel   = we_q ? sdram_wr_ack : sdram_rd_ack;
    assign active    = (state == ST_REQ) || (state == ST_BURST);
    assign beats_nxt = (beats == '1) ? beats : beats + 1'b1;  // saturate, never wrap to a false match

    assign port_ack       = (active && ack_sel) ? port_grant : '0;
    assign sdram_din      = active ? din_arr[g] : '0;
    assign port_dout      = sdram_dout;
    assign sdram_wr_addr  = addr_q;
    assign sdram_rd_addr  = addr_q;
    assign sdram_wr_burst = len_q;
    assign sdram_rd_burst = len_q;

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the counter array is reset because it gates eligibility straight out of reset.
            for (int i = 0; i < NPORT; i++) holdoff[i] <= '0;
        end else begin
            for (int i = 0; i < NPORT; i++) begin
                if (state == ST_DONE && g == IDX_W'(i)) holdoff[i] <= HOLD_W'(HOLDOFF);
                else if (holdoff[i] != '0)              holdoff[i] <= holdoff[i] - 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            g            <= '0;
            rr_ptr       <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            len_q        <= '0;
            wait_cnt     <= '0;
            beats        <= '0;
            ack_r        <= 1'b0;
            err_q        <= 1'b0;
            port_grant   <= '0;
            port_done    <= '0;
            port_err     <= '0;
            sdram_wr_req <= 1'b0;
            sdram_rd_req <= 1'b0;
        end else begin
            ack_r     <= ack_sel;
            port_done <= '0;
            port_err  <= '0;
            case (state)
                ST_IDLE: begin
                    if (sdram_init_done && (|eligible)) begin
                        g          <= pick_idx;
                        we_q       <= port_we[pick_idx];
                        addr_q     <= addr_arr[pick_idx];
                        len_q      <= len_arr[pick_idx];
                        port_grant <= pick;
                        wait_cnt   <= '0;
                        beats      <= '0;
                        err_q      <= (len_arr[pick_idx] == '0);
                        state      <= (len_arr[pick_idx] == '0) ? ST_DONE : ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (ack_sel) begin
                        // The ack-high cycle seen here is already the first beat.
                        sdram_wr_req <= 1'b0;
                        sdram_rd_req <= 1'b0;
                        beats        <= beats_nxt;
                        state        <= ST_BURST;
                    end else if (wait_cnt == WAIT_W'(TIMEOUT)) begin
                        sdram_wr_req <= 1'b0;
                        sdram_rd_req <= 1'b0;
                        err_q        <= 1'b1;
                        state        <= ST_DONE;
                    end else begin
                        sdram_wr_req <= we_q;
                        sdram_rd_req <= ~we_q;
                        wait_cnt     <= wait_cnt + 1'b1;
                    end
                end
                ST_BURST: begin
                    if (ack_sel) beats <= beats_nxt;
                    if (ack_r && !ack_sel) begin
                        err_q <= (beats != len_q);
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    port_done  <= port_grant;
                    port_err   <= err_q ? port_grant : '0;
                    port_grant <= '0;
                    rr_ptr     <= (g == IDX_W'(NPORT - 1)) ? '0 : g + 1'b1;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
